// File: rtl/ecc_err_monitor.sv
// rtl/ecc_err_monitor.sv - SEC-DED result monitor: 2-entry poison-tagged queue, error counters, first-error log, irq
// Optional: define ECC_MON_SGL_IRQ_EN to also raise irq once sgl_cnt reaches SGL_THRESH.
module ecc_err_monitor #(
  parameter int unsigned      CNT_W      = 16,
  parameter int unsigned      ADDR_W     = 16,
  parameter logic [CNT_W-1:0] SGL_THRESH = CNT_W'(8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [38:0]       in_data,
  input  logic [6:0]        in_syn,
  input  logic              in_err,
  input  logic              in_sgl,
  input  logic              in_dbl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_poison,
  output logic [CNT_W-1:0]  sgl_cnt,
  output logic [CNT_W-1:0]  dbl_cnt,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [6:0]        log_syn,
  output logic              log_dbl,
  output logic              log_ovf,
  input  logic              clr,
  output logic              irq
);

  typedef enum logic [1:0] {EMPTY, HOLD_SGL, HOLD_DBL} log_state_e;

`ifdef ECC_MON_SGL_IRQ_EN
  localparam bit SglIrqEn = 1'b1;
`else
  localparam bit SglIrqEn = 1'b0;
`endif
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0]        count_q, count_d, cnt_after_pop;
  logic [32:0]       ent0_q, ent0_d, ent1_q, ent1_d;
  logic              in_ready_q, out_valid_q;
  logic              acc, pop, sgl_ev, dbl_ev;
  logic [CNT_W-1:0]  sgl_cnt_q, sgl_cnt_d, dbl_cnt_q, dbl_cnt_d;
  log_state_e        state_q, state_d, state_base;
  logic [ADDR_W-1:0] log_addr_q, log_addr_d;
  logic [6:0]        log_syn_q, log_syn_d;
  logic              log_dbl_q, log_dbl_d, log_ovf_q, log_ovf_d, log_valid_q;
  logic              irq_q, irq_d;
  logic              unused_in;

  assign unused_in = ^{in_data[38:32], in_err};

  assign acc    = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;
  assign dbl_ev = acc & in_dbl;
  assign sgl_ev = acc & in_sgl & ~in_dbl;

  // Entry 0 is always the head, so out_data/out_poison come straight from a register.
  always_comb begin
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    cnt_after_pop = count_q - {1'b0, pop};
    if (pop) ent0_d = ent1_q;
    if (acc) begin
      if (cnt_after_pop == 2'd0) ent0_d = {in_dbl, in_data[31:0]};
      else                       ent1_d = {in_dbl, in_data[31:0]};
    end
    count_d = cnt_after_pop + {1'b0, acc};
  end

  always_comb begin
    sgl_cnt_d = clr ? '0 : sgl_cnt_q;
    dbl_cnt_d = clr ? '0 : dbl_cnt_q;
    if (sgl_ev && sgl_cnt_d != CntMax) sgl_cnt_d = sgl_cnt_d + CNT_W'(1);
    if (dbl_ev && dbl_cnt_d != CntMax) dbl_cnt_d = dbl_cnt_d + CNT_W'(1);
  end

  // clr is folded in first so a coincident event lands on a freshly cleared log.
  always_comb begin
    state_base = clr ? EMPTY : state_q;
    state_d    = state_base;
    log_addr_d = clr ? '0 : log_addr_q;
    log_syn_d  = clr ? '0 : log_syn_q;
    log_dbl_d  = clr ? 1'b0 : log_dbl_q;
    log_ovf_d  = clr ? 1'b0 : log_ovf_q;
    if (sgl_ev || dbl_ev) begin
      unique case (state_base)
        EMPTY: begin
          log_addr_d = in_addr;
          log_syn_d  = in_syn;
          log_dbl_d  = dbl_ev;
          state_d    = dbl_ev ? HOLD_DBL : HOLD_SGL;
        end
        HOLD_SGL: begin
          log_ovf_d = 1'b1;
          if (dbl_ev) begin
            log_addr_d = in_addr;
            log_syn_d  = in_syn;
            log_dbl_d  = 1'b1;
            state_d    = HOLD_DBL;
          end
        end
        default: log_ovf_d = 1'b1;
      endcase
    end
    irq_d = ~clr & (irq_q | log_dbl_q | (SglIrqEn & (sgl_cnt_q >= SGL_THRESH)));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sgl_cnt_q   <= '0;
      dbl_cnt_q   <= '0;
      log_addr_q  <= '0;
      log_syn_q   <= '0;
      log_dbl_q   <= 1'b0;
      log_ovf_q   <= 1'b0;
      log_valid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      in_ready_q  <= (count_d < 2'd2);
      out_valid_q <= (count_d != 2'd0);
      sgl_cnt_q   <= sgl_cnt_d;
      dbl_cnt_q   <= dbl_cnt_d;
      log_addr_q  <= log_addr_d;
      log_syn_q   <= log_syn_d;
      log_dbl_q   <= log_dbl_d;
      log_ovf_q   <= log_ovf_d;
      log_valid_q <= (state_d != EMPTY);
      irq_q       <= irq_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = ent0_q[31:0];
  assign out_poison = ent0_q[32];
  assign sgl_cnt    = sgl_cnt_q;
  assign dbl_cnt    = dbl_cnt_q;
  assign log_valid  = log_valid_q;
  assign log_addr   = log_addr_q;
  assign log_syn    = log_syn_q;
  assign log_dbl    = log_dbl_q;
  assign log_ovf    = log_ovf_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_ecc_err_monitor.sv
// tb/tb_ecc_err_monitor.sv - randomized bench for ecc_err_monitor against a queue-based reference model
module tb_ecc_err_monitor;
  localparam int CW   = 4;
  localparam int AW   = 16;
  localparam int THR  = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ECC_MON_SGL_IRQ_EN
  localparam bit SGL_EN = 1'b1;
`else
  localparam bit SGL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_err, in_sgl, in_dbl, out_ready, clr;
  logic [AW-1:0] in_addr;
  logic [38:0]   in_data;
  logic [6:0]    in_syn;
  logic          in_ready, out_valid, out_poison, log_valid, log_dbl, log_ovf, irq;
  logic [31:0]   out_data;
  logic [CW-1:0] sgl_cnt, dbl_cnt;
  logic [AW-1:0] log_addr;
  logic [6:0]    log_syn;

  always #5 clk = ~clk;

  ecc_err_monitor #(.CNT_W(CW), .ADDR_W(AW), .SGL_THRESH(CW'(THR))) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .in_syn(in_syn), .in_err(in_err), .in_sgl(in_sgl), .in_dbl(in_dbl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_poison(out_poison),
    .sgl_cnt(sgl_cnt), .dbl_cnt(dbl_cnt), .log_valid(log_valid), .log_addr(log_addr),
    .log_syn(log_syn), .log_dbl(log_dbl), .log_ovf(log_ovf), .clr(clr), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of {poison, data}, integer counters, log as plain flags.
  logic [32:0]   mq[$];
  int            m_sgl, m_dbl;
  bit            m_lv, m_ldbl, m_lovf, m_irq, m_init;
  logic [AW-1:0] m_laddr;
  logic [6:0]    m_lsyn;

  initial begin
    m_init = 1'b0;
    forever begin
      @(posedge clk);
      m_init = 1'b1;
      if (rst) begin
        mq.delete();
        m_sgl = 0; m_dbl = 0;
        m_lv = 0; m_ldbl = 0; m_lovf = 0; m_irq = 0; m_laddr = '0; m_lsyn = '0;
      end else begin
        bit acc, pop, irq_n;
        acc   = in_valid && (mq.size() < 2);
        pop   = (mq.size() > 0) && out_ready;
        irq_n = !clr && (m_irq || m_ldbl || (SGL_EN && m_sgl >= THR));
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({in_dbl, in_data[31:0]});
        if (clr) begin
          m_sgl = 0; m_dbl = 0; m_lv = 0; m_ldbl = 0; m_lovf = 0;
        end
        if (acc && in_dbl) begin
          if (m_dbl < CMAX) m_dbl++;
          if (m_lv && m_ldbl) m_lovf = 1;
          else begin
            if (m_lv) m_lovf = 1;
            m_lv = 1; m_ldbl = 1; m_laddr = in_addr; m_lsyn = in_syn;
          end
        end else if (acc && in_sgl) begin
          if (m_sgl < CMAX) m_sgl++;
          if (m_lv) m_lovf = 1;
          else begin
            m_lv = 1; m_ldbl = 0; m_laddr = in_addr; m_lsyn = in_syn;
          end
        end
        m_irq = irq_n;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("in_ready", in_ready, mq.size() < 2);
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
          check("out_data", out_data, mq[0][31:0]);
          check("out_poison", out_poison, mq[0][32]);
        end
        check("sgl_cnt", sgl_cnt, m_sgl);
        check("dbl_cnt", dbl_cnt, m_dbl);
        check("log_valid", log_valid, m_lv);
        check("log_dbl", log_dbl, m_ldbl);
        check("log_ovf", log_ovf, m_lovf);
        check("irq", irq, m_irq);
        if (m_lv) begin
          check("log_addr", log_addr, m_laddr);
          check("log_syn", log_syn, m_lsyn);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [AW-1:0] a, input logic [38:0] d,
                       input logic [6:0] s, input bit sg, input bit db, input bit ordy, input bit c);
    in_valid = v; in_addr = a; in_data = d; in_syn = s; in_err = (s != 0);
    in_sgl = sg; in_dbl = db; out_ready = ordy; clr = c;
    @(negedge clk);
  endtask

  initial begin
    logic [38:0] w[4];
    logic [38:0] wa, wb, wc;
    w[0] = 39'h11_1111_0001; w[1] = 39'h22_2222_0002; w[2] = 39'h33_3333_0003; w[3] = 39'h44_4444_0004;
    wa = 39'h05_AAAA_0A0A; wb = 39'h06_BBBB_0B0B; wc = 39'h07_CCCC_0C0C;

    rst = 1'b1;
    drive(0, '0, '0, '0, 0, 0, 0, 0);
    drive(0, '0, '0, '0, 0, 0, 0, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      drive(1, AW'(i), w[i], '0, 0, 0, 1, 0);
      check("stream_data", out_data, w[i][31:0]);
      check("stream_poison", out_poison, 0);
    end
    check("stream_sgl_cnt", sgl_cnt, 0);
    check("stream_log_valid", log_valid, 0);
    drive(0, '0, '0, '0, 0, 0, 1, 0);

    drive(1, 16'h0001, wa, '0, 0, 0, 0, 0);
    drive(1, 16'h0002, wb, '0, 0, 0, 0, 0);
    check("bp_full_ready", in_ready, 0);
    check("bp_head_a", out_data, wa[31:0]);
    drive(1, 16'h0003, wc, '0, 0, 0, 0, 0);
    check("bp_stall_a", out_data, wa[31:0]);
    drive(1, 16'h0003, wc, '0, 0, 0, 1, 0);
    check("bp_head_b", out_data, wb[31:0]);
    check("bp_reraise", in_ready, 1);
    drive(1, 16'h0003, wc, '0, 0, 0, 1, 0);
    check("bp_head_c", out_data, wc[31:0]);
    drive(0, '0, '0, '0, 0, 0, 1, 0);
    check("bp_drained", out_valid, 0);

    drive(1, 16'h0010, 39'h00_0000_5151, 7'b0000111, 1, 0, 1, 0);
    check("sd_laddr1", log_addr, 16'h0010);
    check("sd_ldbl1", log_dbl, 0);
    drive(1, 16'h0020, 39'h00_0000_D2D2, 7'b0000011, 0, 1, 1, 0);
    check("sd_laddr2", log_addr, 16'h0020);
    check("sd_ldbl2", log_dbl, 1);
    check("sd_lovf", log_ovf, 1);
    check("sd_dbl_cnt", dbl_cnt, 1);
    check("sd_poison", out_poison, 1);
    check("sd_irq_early", irq, 0);
    drive(0, '0, '0, '0, 0, 0, 1, 0);
    check("sd_irq", irq, 1);
    drive(0, '0, '0, '0, 0, 0, 1, 1);
    check("clr_irq", irq, 0);
    check("clr_log_valid", log_valid, 0);

    for (int i = 0; i < 17; i++)
      drive(1, AW'(16'h0100 + i), {7'h0, $urandom()}, 7'h0B, 1, 0, 1, 0);
    check("sat_sgl_cnt", sgl_cnt, 4'hF);

    drive(1, 16'h0033, 39'h00_0000_3333, 7'h15, 1, 0, 1, 1);
    check("clrev_sgl_cnt", sgl_cnt, 1);
    check("clrev_dbl_cnt", dbl_cnt, 0);
    check("clrev_laddr", log_addr, 16'h0033);
    check("clrev_lovf", log_ovf, 0);
    check("clrev_irq", irq, 0);

    drive(0, '0, '0, '0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++)
      drive(1, AW'(16'h0200 + i), 39'h00_0000_7777, 7'h21, 1, 0, 1, 0);
    check("thr_cnt", sgl_cnt, 3);
    check("thr_irq_early", irq, 0);
    drive(0, '0, '0, '0, 0, 0, 1, 0);
    check("thr_irq", irq, SGL_EN);

    for (int i = 0; i < 3000; i++) begin
      int r;
      r   = int'($urandom_range(0, 9));
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 1) == 1, AW'($urandom()), {7'($urandom()), $urandom()},
            7'($urandom()), (r < 6) || (r == 0 && $urandom_range(0, 1) == 1), r < 2,
            $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
    end
    rst = 1'b0;
    drive(0, '0, '0, '0, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
